// File: rtl/core_node_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : core_node_scheduler_if
// Purpose  : Handshake/bus bundle between the node scheduler and its
//            controller/ALU environment.
// Ports    : master modport - controller side (drives start/abort/config and
//                             alu_done, observes selectors and status)
//            slave modport  - scheduler side (the reverse directions)
// Revision : 1.0 - initial release
// ============================================================================
interface core_node_scheduler_if #(
  parameter int WIDTH         = 32,
  parameter int NODE_CONTAINS = 5
);
  logic                     start;
  logic                     abort;
  logic [NODE_CONTAINS-1:0] node_mask;
  logic [WIDTH-1:0]         iter_limit;
  logic                     alu_done;
  logic [WIDTH-1:0]         v_selector;
  logic [WIDTH-1:0]         f_selector;
  logic                     alu_start;
  logic                     wb_en;
  logic [7:0]               node_idx;
  logic [WIDTH-1:0]         round_count;
  logic                     busy;
  logic                     done;

  modport master (
    output start, abort, node_mask, iter_limit, alu_done,
    input  v_selector, f_selector, alu_start, wb_en, node_idx,
           round_count, busy, done
  );

  modport slave (
    input  start, abort, node_mask, iter_limit, alu_done,
    output v_selector, f_selector, alu_start, wb_en, node_idx,
           round_count, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/core_node_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : core_node_scheduler
// Purpose  : Walks the active nodes of the node RAM in ascending index order,
//            driving one-hot current (v) and predecessor (f) selectors into
//            the ALU input selector. Each node gets one ALU launch, a wait for
//            completion and a write-back strobe. The closed chain is walked
//            for iter_limit rounds, then done pulses.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - core_node_scheduler_if.slave (start/abort/node_mask/
//                   iter_limit/alu_done in; v_selector/f_selector/alu_start/
//                   wb_en/node_idx/round_count/busy/done out)
// Notes    : WIDTH must be >= NODE_CONTAINS, NODE_CONTAINS <= 256.
// Revision : 1.0 - initial release
// ============================================================================
module core_node_scheduler #(
  parameter int WIDTH         = 32,
  parameter int NODE_CONTAINS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  core_node_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  // Index of the lowest set bit (0 for an empty mask).
  function automatic logic [7:0] lowest_set(input logic [NODE_CONTAINS-1:0] m);
    lowest_set = '0;
    for (int i = NODE_CONTAINS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 8'(i);
    end
  endfunction

  // Index of the highest set bit (0 for an empty mask).
  function automatic logic [7:0] highest_set(input logic [NODE_CONTAINS-1:0] m);
    highest_set = '0;
    for (int i = 0; i < NODE_CONTAINS; i++) begin
      if (m[i]) highest_set = 8'(i);
    end
  endfunction

  // Next set bit strictly above idx; returns idx if none exists.
  function automatic logic [7:0] next_above(input logic [NODE_CONTAINS-1:0] m,
                                            input logic [7:0] idx);
    logic found;
    found      = 1'b0;
    next_above = idx;
    for (int i = 0; i < NODE_CONTAINS; i++) begin
      if (!found && m[i] && (8'(i) > idx)) begin
        next_above = 8'(i);
        found      = 1'b1;
      end
    end
  endfunction

  // One-hot decode limited to the node slots, so bits >= NODE_CONTAINS stay 0.
  function automatic logic [WIDTH-1:0] onehot(input logic [7:0] idx);
    onehot = '0;
    for (int i = 0; i < NODE_CONTAINS; i++) begin
      if (idx == 8'(i)) onehot[i] = 1'b1;
    end
  endfunction

  state_t                   r_state;
  logic [NODE_CONTAINS-1:0] r_mask;
  logic [WIDTH-1:0]         r_limit;
  logic [WIDTH-1:0]         r_round;
  logic [7:0]               r_first;
  logic [7:0]               r_last;
  logic [7:0]               r_cur;
  logic [7:0]               r_prev;
  logic [WIDTH-1:0]         r_v_sel;
  logic [WIDTH-1:0]         r_f_sel;
  logic                     r_alu_start;
  logic                     r_wb_en;
  logic                     r_done;
  logic                     r_busy;

  logic [7:0]               w_first;
  logic [7:0]               w_last;
  logic [7:0]               w_next;
  logic [WIDTH-1:0]         w_round_plus;
  logic [WIDTH-1:0]         w_round_sat;
  logic                     w_abort_now;

  assign w_first      = lowest_set(bus.node_mask);
  assign w_last       = highest_set(bus.node_mask);
  assign w_next       = next_above(r_mask, r_cur);
  // Wrapping sum is used for the limit compare: at all-ones it becomes 0,
  // which never matches a non-zero limit, so a saturated run keeps going.
  assign w_round_plus = r_round + c_one;
  assign w_round_sat  = (r_round == '1) ? r_round : w_round_plus;
  assign w_abort_now  = bus.abort && (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_limit     <= '0;
      r_round     <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_cur       <= '0;
      r_prev      <= '0;
      r_v_sel     <= '0;
      r_f_sel     <= '0;
      r_alu_start <= 1'b0;
      r_wb_en     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_abort_now) begin
      // Abort wins over everything; counters and indices are left as-is.
      r_state     <= ST_IDLE;
      r_v_sel     <= '0;
      r_f_sel     <= '0;
      r_alu_start <= 1'b0;
      r_wb_en     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_wb_en     <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mask  <= bus.node_mask;
            r_limit <= bus.iter_limit;
            r_round <= '0;
            r_first <= w_first;
            r_last  <= w_last;
            r_busy  <= 1'b1;
            if ((bus.node_mask == '0) || (bus.iter_limit == '0)) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_cur       <= w_first;
              r_prev      <= w_last;
              r_v_sel     <= onehot(w_first);
              r_f_sel     <= onehot(w_last);
              r_alu_start <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.alu_done) begin
            r_wb_en <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (r_cur != r_last) begin
            r_prev      <= r_cur;
            r_cur       <= w_next;
            r_f_sel     <= r_v_sel;
            r_v_sel     <= onehot(w_next);
            r_alu_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (w_round_plus == r_limit) begin
            r_round <= w_round_sat;
            r_v_sel <= '0;
            r_f_sel <= '0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_round     <= w_round_sat;
            r_prev      <= r_last;
            r_cur       <= r_first;
            r_v_sel     <= onehot(r_first);
            r_f_sel     <= onehot(r_last);
            r_alu_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pulses are masked in the abort cycle itself, not only from the next one.
  assign bus.alu_start   = r_alu_start & ~w_abort_now;
  assign bus.wb_en       = r_wb_en & ~w_abort_now;
  assign bus.done        = r_done & ~w_abort_now;
  assign bus.v_selector  = r_v_sel;
  assign bus.f_selector  = r_f_sel;
  assign bus.node_idx    = r_cur;
  assign bus.round_count = r_round;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire
